aurora_lane_init_sm: RTL and testbench
======================================

Name: aurora_lane_init_sm

Overview:
- Receive-side lane initialisation and monitoring controller for a single 2-byte Aurora 8b10b lane.
- Sits between the GTP transceiver wrapper and the lane logic. Consumes the wrapper's decoded RX outputs and drives its RX reset, comma-alignment enable and RX polarity inputs.
- Brings the lane through reset, comma alignment, polarity detection and /SP/ verification, then asserts LANE_UP.
- Once the lane is up, it monitors disparity and not-in-table errors and RX buffer errors, and forces re-initialisation when the error rate is too high.

Parameters:
- RST_CYCLES, 8: cycles RXRESET_OUT is held in RST (min 2).
- ALIGN_TIMEOUT, 4096: cycles allowed in ALIGN or VERIFY before restarting at RST.
- GOOD_SP, 4: consecutive good /SP/ words needed to declare lane up.
- ERR_THRESH, 15: leaky-bucket error count that triggers HARD_ERR (max 255).
- ERR_LEAK, 256: cycles between bucket decrements.

Ports:
- USER_CLK  in  1  lane user clock (RXUSRCLK2 domain)
- RESET  in  1  synchronous, active-high reset
- RESETDONE_IN  in  1  GTP reset done
- RXDATA_IN  in  16  decoded RX data; [15:8] is the first byte
- RXCHARISK_IN  in  2  K flags; [1] pairs with [15:8]
- RXCHARISCOMMA_IN  in  2  comma flags
- RXDISPERR_IN  in  2  disparity error flags
- RXNOTINTABLE_IN  in  2  not-in-table flags
- RXREALIGN_IN  in  1  byte realign pulse
- RXBUFERR_IN  in  1  RX elastic buffer error
- RXRESET_OUT  out  1  to wrapper RXRESET_IN
- ENCOMMAALIGN_OUT  out  1  drives both ENMCOMMAALIGN and ENPCOMMAALIGN
- RXPOLARITY_OUT  out  1  to wrapper RXPOLARITY_IN
- LANE_UP  out  1  lane initialised
- SOFT_ERR  out  1  per-cycle decode error pulse while lane up
- HARD_ERR  out  1  one-cycle pulse on forced re-initialisation

Behaviour:
- Reset and clocking
  - Everything is single-clock on USER_CLK. The reset is synchronous active-high, sampled on the USER_CLK rising edge.
  - On RESET: state=RST, all counters 0, RXRESET_OUT=1, ENCOMMAALIGN_OUT=0, RXPOLARITY_OUT=0, LANE_UP=0, SOFT_ERR=0, HARD_ERR=0.
  - RESET asserted mid-operation has the same effect on the next edge, including clearing RXPOLARITY_OUT.
- Output timing
  - All outputs are registered.
  - State-decoded outputs take their new value in the first cycle the state register holds the new state.
- Definitions
  - /SP/ good: RXCHARISK_IN=2'b10, RXDATA_IN=16'hBC95 or 16'h9595.
  - /SP/ inverted: RXDATA_IN=16'hBC4A with RXCHARISK_IN=2'b10, or 16'h4A4A with RXCHARISK_IN=2'b00.
  - dec_err: |(RXDISPERR_IN|RXNOTINTABLE_IN).
- States
  - RST
    - RXRESET_OUT=1, counter counts to RST_CYCLES.
    - Then go to WAIT_DONE.
  - WAIT_DONE
    - RXRESET_OUT=0.
    - Go to ALIGN when RESETDONE_IN=1; no timeout.
  - ALIGN
    - ENCOMMAALIGN_OUT=1, timeout counter runs.
    - On a cycle with RXCHARISCOMMA_IN[1]=1 and RXREALIGN_IN=0, go to VERIFY.
    - A comma in byte [0] only is misaligned: stay in ALIGN.
    - On timeout, go to RST.
  - VERIFY
    - ENCOMMAALIGN_OUT=0.
    - A good /SP/ increments sp_cnt. Any other K word, or dec_err, clears sp_cnt. Data words with no error leave sp_cnt unchanged.
    - When sp_cnt reaches GOOD_SP, go to READY.
    - An inverted /SP/ toggles RXPOLARITY_OUT and goes to RST. The polarity value is preserved through RST; only RESET clears it.
    - RXREALIGN_IN=1 goes back to ALIGN.
    - Timeout (counter restarted on VERIFY entry) goes to RST.
  - READY
    - LANE_UP=1.
    - SOFT_ERR is a registered copy of dec_err.
    - Leaky bucket (8-bit, saturating):
      - +1 on each dec_err cycle.
      - -1 every ERR_LEAK cycles if nonzero.
      - On a simultaneous increment and leak, the count is unchanged.
    - When the bucket reaches >= ERR_THRESH, or on RXBUFERR_IN=1, or on RXREALIGN_IN=1: pulse HARD_ERR for 1 cycle (the first cycle of RST), then go to RST.
- Counter behaviour
  - Bucket, sp_cnt and the timeout counter clear on every state change.
  - The leak timer wraps at ERR_LEAK-1 to 0.
- Priority in READY (highest first): RXBUFERR_IN, threshold, realign.
- Outside READY: LANE_UP=0 and SOFT_ERR=0.

Test Plan:
- Nominal bring-up with RST_CYCLES=8, no errors:
  - RESET 2 cycles, then RESETDONE_IN=1 from cycle 12, comma in byte [1] at cycle 20, then 4×16'hBC95/K=10.
  - Required: RXRESET_OUT high exactly 8 cycles, ENCOMMAALIGN_OUT high from entry to ALIGN until VERIFY, LANE_UP=1 the cycle after the 4th /SP/, RXPOLARITY_OUT=0.
- Inverted polarity:
  - In VERIFY, drive 16'hBC4A/K=10.
  - Required: RXPOLARITY_OUT toggles to 1, RXRESET_OUT reasserts for 8 cycles. A subsequent good-/SP/ sequence reaches LANE_UP with RXPOLARITY_OUT still 1.
- Alignment timeout with ALIGN_TIMEOUT=64:
  - Only byte-[0] commas are presented.
  - Required: return to RST at cycle 64 of ALIGN, LANE_UP never asserted.
- Error threshold with ERR_THRESH=15, ERR_LEAK=256:
  - In READY, 15 consecutive RXDISPERR_IN=2'b01.
  - Required: SOFT_ERR=1 on each of those cycles, HARD_ERR single pulse, LANE_UP drops, state returns to RST.
  - Separately, 1 error per 300 cycles never triggers HARD_ERR.
- Buffer error and mid-operation reset:
  - RXBUFERR_IN=1 pulse in READY gives a HARD_ERR pulse and RST.
  - RESET asserted in READY with RXPOLARITY_OUT=1 clears all outputs to their reset values on the next edge.

Source files
------------

// File: rtl/aurora_lane_init_sm.sv
// Receive-side lane initialisation and monitoring controller for one 2-byte
// Aurora 8b10b lane. Walks the lane through RX reset, comma alignment,
// polarity detection and /SP/ verification, then raises LANE_UP and watches
// decode/buffer errors with a leaky bucket, forcing re-init when needed.
//
// Ports:
//   USER_CLK          lane user clock (RXUSRCLK2 domain)
//   RESET             synchronous active-high reset
//   RESETDONE_IN      transceiver reset done
//   RXDATA_IN[15:0]   decoded RX data, [15:8] is the first byte
//   RXCHARISK_IN[1:0] K flags, [1] pairs with [15:8]
//   RXCHARISCOMMA_IN  comma flags
//   RXDISPERR_IN      disparity error flags
//   RXNOTINTABLE_IN   not-in-table flags
//   RXREALIGN_IN      byte realign pulse
//   RXBUFERR_IN       RX elastic buffer error
//   RXRESET_OUT       to transceiver RX reset
//   ENCOMMAALIGN_OUT  comma alignment enable (both M and P)
//   RXPOLARITY_OUT    RX polarity select
//   LANE_UP           lane initialised
//   SOFT_ERR          per-cycle decode error pulse while lane up
//   HARD_ERR          one-cycle pulse on forced re-initialisation
module aurora_lane_init_sm #(
   parameter int unsigned RST_CYCLES    = 8,
   parameter int unsigned ALIGN_TIMEOUT = 4096,
   parameter int unsigned GOOD_SP       = 4,
   parameter int unsigned ERR_THRESH    = 15,
   parameter int unsigned ERR_LEAK      = 256
) (
   input  logic        USER_CLK,
   input  logic        RESET,
   input  logic        RESETDONE_IN,
   input  logic [15:0] RXDATA_IN,
   input  logic [1:0]  RXCHARISK_IN,
   input  logic [1:0]  RXCHARISCOMMA_IN,
   input  logic [1:0]  RXDISPERR_IN,
   input  logic [1:0]  RXNOTINTABLE_IN,
   input  logic        RXREALIGN_IN,
   input  logic        RXBUFERR_IN,
   output logic        RXRESET_OUT,
   output logic        ENCOMMAALIGN_OUT,
   output logic        RXPOLARITY_OUT,
   output logic        LANE_UP,
   output logic        SOFT_ERR,
   output logic        HARD_ERR
);

   // One shared counter serves as reset timer, align/verify timeout and leak timer
   localparam int unsigned CNT_MAX_A = (RST_CYCLES > ALIGN_TIMEOUT) ? RST_CYCLES : ALIGN_TIMEOUT;
   localparam int unsigned CNT_MAX   = (CNT_MAX_A > ERR_LEAK) ? CNT_MAX_A : ERR_LEAK;
   localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
   localparam int unsigned SP_W      = $clog2(GOOD_SP + 1);
   localparam int unsigned BKT_W     = 8;

   typedef enum logic [2:0] {
      ST_RST,
      ST_WAIT_DONE,
      ST_ALIGN,
      ST_VERIFY,
      ST_READY
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [SP_W-1:0]    sp_cnt;
   logic [BKT_W-1:0]   bucket;

   logic dec_err;
   logic sp_good;
   logic sp_inv;
   logic k_word;
   logic comma_hi;
   logic leak;
   logic ready_fault;

   // Word classification
   assign dec_err  = |(RXDISPERR_IN | RXNOTINTABLE_IN);
   assign sp_good  = (RXCHARISK_IN == 2'b10) &&
                     ((RXDATA_IN == 16'hBC95) || (RXDATA_IN == 16'h9595));
   assign sp_inv   = ((RXCHARISK_IN == 2'b10) && (RXDATA_IN == 16'hBC4A)) ||
                     ((RXCHARISK_IN == 2'b00) && (RXDATA_IN == 16'h4A4A));
   assign k_word   = |RXCHARISK_IN;
   // Only a comma in the first byte means the lane is word aligned
   assign comma_hi = RXCHARISCOMMA_IN inside {2'b10, 2'b11};

   // Leak only applies when the timer wraps and the bucket holds something
   assign leak        = (cnt == CNT_W'(ERR_LEAK - 1)) && (bucket != '0);
   // Buffer error, threshold and realign all lead to the same re-init
   assign ready_fault = RXBUFERR_IN || (bucket >= BKT_W'(ERR_THRESH)) || RXREALIGN_IN;

   // State register with outputs assigned alongside each transition
   always_ff @(posedge USER_CLK) begin
      SOFT_ERR <= 1'b0;
      HARD_ERR <= 1'b0;
      if (RESET) begin
         state            <= ST_RST;
         cnt              <= '0;
         sp_cnt           <= '0;
         bucket           <= '0;
         RXRESET_OUT      <= 1'b1;
         ENCOMMAALIGN_OUT <= 1'b0;
         RXPOLARITY_OUT   <= 1'b0;
         LANE_UP          <= 1'b0;
      end else begin
         case (state)
            ST_RST: begin
               if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                  state       <= ST_WAIT_DONE;
                  cnt         <= '0;
                  RXRESET_OUT <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            ST_WAIT_DONE: begin
               if (RESETDONE_IN) begin
                  state            <= ST_ALIGN;
                  cnt              <= '0;
                  ENCOMMAALIGN_OUT <= 1'b1;
               end
            end

            ST_ALIGN: begin
               if (comma_hi && !RXREALIGN_IN) begin
                  state            <= ST_VERIFY;
                  cnt              <= '0;
                  sp_cnt           <= '0;
                  ENCOMMAALIGN_OUT <= 1'b0;
               end else if (cnt == CNT_W'(ALIGN_TIMEOUT - 1)) begin
                  state            <= ST_RST;
                  cnt              <= '0;
                  ENCOMMAALIGN_OUT <= 1'b0;
                  RXRESET_OUT      <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            ST_VERIFY: begin
               if (RXREALIGN_IN) begin
                  state            <= ST_ALIGN;
                  cnt              <= '0;
                  sp_cnt           <= '0;
                  ENCOMMAALIGN_OUT <= 1'b1;
               end else if (sp_inv) begin
                  // Polarity survives the reset pass; only RESET clears it
                  state          <= ST_RST;
                  cnt            <= '0;
                  sp_cnt         <= '0;
                  RXPOLARITY_OUT <= ~RXPOLARITY_OUT;
                  RXRESET_OUT    <= 1'b1;
               end else if (sp_good && !dec_err && (sp_cnt == SP_W'(GOOD_SP - 1))) begin
                  state   <= ST_READY;
                  cnt     <= '0;
                  sp_cnt  <= '0;
                  bucket  <= '0;
                  LANE_UP <= 1'b1;
               end else if (cnt == CNT_W'(ALIGN_TIMEOUT - 1)) begin
                  state       <= ST_RST;
                  cnt         <= '0;
                  sp_cnt      <= '0;
                  RXRESET_OUT <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
                  if (dec_err) begin
                     sp_cnt <= '0;
                  end else if (sp_good) begin
                     sp_cnt <= sp_cnt + SP_W'(1);
                  end else if (k_word) begin
                     sp_cnt <= '0;
                  end
               end
            end

            ST_READY: begin
               if (ready_fault) begin
                  state       <= ST_RST;
                  cnt         <= '0;
                  bucket      <= '0;
                  LANE_UP     <= 1'b0;
                  RXRESET_OUT <= 1'b1;
                  HARD_ERR    <= 1'b1;
               end else begin
                  SOFT_ERR <= dec_err;
                  cnt      <= (cnt == CNT_W'(ERR_LEAK - 1)) ? '0 : cnt + CNT_W'(1);
                  // Simultaneous increment and leak cancel out
                  if (dec_err && !leak && (bucket != {BKT_W{1'b1}})) begin
                     bucket <= bucket + BKT_W'(1);
                  end else if (leak && !dec_err) begin
                     bucket <= bucket - BKT_W'(1);
                  end
               end
            end

            default: begin
               state            <= ST_RST;
               cnt              <= '0;
               sp_cnt           <= '0;
               bucket           <= '0;
               RXRESET_OUT      <= 1'b1;
               ENCOMMAALIGN_OUT <= 1'b0;
               LANE_UP          <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aurora_lane_init_sm.sv
// Self-checking bench for aurora_lane_init_sm: a phase/age model of the lane
// bring-up is compared every cycle, and directed scenarios pin key timings.
module tb_aurora_lane_init_sm;

   localparam int unsigned RST_N = 8;
   localparam int unsigned TO    = 64;
   localparam int unsigned GSP   = 4;
   localparam int unsigned THR   = 15;
   localparam int unsigned LEAK  = 256;

   localparam int P_RST = 0, P_WAIT = 1, P_ALIGN = 2, P_VERIFY = 3, P_READY = 4;

   logic        USER_CLK;
   logic        RESET;
   logic        RESETDONE_IN;
   logic [15:0] RXDATA_IN;
   logic [1:0]  RXCHARISK_IN;
   logic [1:0]  RXCHARISCOMMA_IN;
   logic [1:0]  RXDISPERR_IN;
   logic [1:0]  RXNOTINTABLE_IN;
   logic        RXREALIGN_IN;
   logic        RXBUFERR_IN;
   logic        RXRESET_OUT;
   logic        ENCOMMAALIGN_OUT;
   logic        RXPOLARITY_OUT;
   logic        LANE_UP;
   logic        SOFT_ERR;
   logic        HARD_ERR;

   int checks   = 0;
   int failures = 0;

   aurora_lane_init_sm #(
      .RST_CYCLES   (RST_N),
      .ALIGN_TIMEOUT(TO),
      .GOOD_SP      (GSP),
      .ERR_THRESH   (THR),
      .ERR_LEAK     (LEAK)
   ) dut (
      .USER_CLK        (USER_CLK),
      .RESET           (RESET),
      .RESETDONE_IN    (RESETDONE_IN),
      .RXDATA_IN       (RXDATA_IN),
      .RXCHARISK_IN    (RXCHARISK_IN),
      .RXCHARISCOMMA_IN(RXCHARISCOMMA_IN),
      .RXDISPERR_IN    (RXDISPERR_IN),
      .RXNOTINTABLE_IN (RXNOTINTABLE_IN),
      .RXREALIGN_IN    (RXREALIGN_IN),
      .RXBUFERR_IN     (RXBUFERR_IN),
      .RXRESET_OUT     (RXRESET_OUT),
      .ENCOMMAALIGN_OUT(ENCOMMAALIGN_OUT),
      .RXPOLARITY_OUT  (RXPOLARITY_OUT),
      .LANE_UP         (LANE_UP),
      .SOFT_ERR        (SOFT_ERR),
      .HARD_ERR        (HARD_ERR)
   );

   initial begin
      USER_CLK = 1'b0;
      forever #5 USER_CLK = ~USER_CLK;
   end

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Tracks which phase the lane is in and how many cycles it has spent there.
   bit m_valid = 0;
   int m_phase = P_RST;
   int m_age   = 0;
   int m_good  = 0;
   int m_bkt   = 0;
   bit m_pol   = 0;
   bit m_soft  = 0;
   bit m_hard  = 0;

   always @(posedge USER_CLK) begin
      int nxt;
      int k;
      bit dec;
      bit spg;
      bit spi;
      int lk;
      dec = |(RXDISPERR_IN | RXNOTINTABLE_IN);
      spg = (RXCHARISK_IN == 2'b10) && (RXDATA_IN == 16'hBC95 || RXDATA_IN == 16'h9595);
      spi = (RXCHARISK_IN == 2'b10 && RXDATA_IN == 16'hBC4A) ||
            (RXCHARISK_IN == 2'b00 && RXDATA_IN == 16'h4A4A);
      k      = m_age + 1;
      nxt    = m_phase;
      m_soft = 0;
      m_hard = 0;
      if (RESET) begin
         m_valid = 1;
         m_phase = P_RST;
         m_age   = 0;
         m_good  = 0;
         m_bkt   = 0;
         m_pol   = 0;
      end else if (m_valid) begin
         case (m_phase)
            P_RST:   if (k >= int'(RST_N)) nxt = P_WAIT;
            P_WAIT:  if (RESETDONE_IN) nxt = P_ALIGN;
            P_ALIGN: begin
               if (RXCHARISCOMMA_IN[1] && !RXREALIGN_IN) nxt = P_VERIFY;
               else if (k >= int'(TO)) nxt = P_RST;
            end
            P_VERIFY: begin
               if (RXREALIGN_IN) nxt = P_ALIGN;
               else if (spi) begin
                  m_pol = !m_pol;
                  nxt   = P_RST;
               end else begin
                  if (dec) m_good = 0;
                  else if (spg) m_good = m_good + 1;
                  else if (RXCHARISK_IN != 2'b00) m_good = 0;
                  if (m_good >= int'(GSP)) nxt = P_READY;
                  else if (k >= int'(TO)) nxt = P_RST;
               end
            end
            default: begin
               if (RXBUFERR_IN || m_bkt >= int'(THR) || RXREALIGN_IN) begin
                  nxt    = P_RST;
                  m_hard = 1;
               end else begin
                  m_soft = dec;
                  lk = ((k % int'(LEAK)) == 0 && m_bkt > 0) ? 1 : 0;
                  m_bkt = m_bkt + (dec ? 1 : 0) - lk;
                  if (m_bkt > 255) m_bkt = 255;
               end
            end
         endcase
         if (nxt != m_phase) begin
            m_age  = 0;
            m_good = 0;
            m_bkt  = 0;
         end else begin
            m_age = k;
         end
         m_phase = nxt;
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge USER_CLK) begin
      if (m_valid) begin
         chk("m_rxreset", RXRESET_OUT, m_phase == P_RST);
         chk("m_encomma", ENCOMMAALIGN_OUT, m_phase == P_ALIGN);
         chk("m_lane_up", LANE_UP, m_phase == P_READY);
         chk("m_polarity", RXPOLARITY_OUT, m_pol);
         chk("m_soft_err", SOFT_ERR, m_soft);
         chk("m_hard_err", HARD_ERR, m_hard);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge USER_CLK);
      #1;
   endtask

   task automatic drive(input logic [15:0] d, input logic [1:0] k, input logic [1:0] c);
      RXDATA_IN        = d;
      RXCHARISK_IN     = k;
      RXCHARISCOMMA_IN = c;
      RXDISPERR_IN     = 2'b00;
      RXNOTINTABLE_IN  = 2'b00;
      RXREALIGN_IN     = 1'b0;
      RXBUFERR_IN      = 1'b0;
   endtask

   task automatic idle();
      drive(16'h0000, 2'b00, 2'b00);
   endtask

   function automatic logic get_out(input int which);
      case (which)
         0:       return RXRESET_OUT;
         1:       return ENCOMMAALIGN_OUT;
         default: return LANE_UP;
      endcase
   endfunction

   task automatic wait_out(input string name, input int which, input logic val, input int limit);
      int i;
      i = 0;
      while (get_out(which) !== val && i < limit) begin
         step();
         i++;
      end
      chk(name, get_out(which), val);
   endtask

   task automatic count_rxreset(output int n);
      n = 0;
      while (RXRESET_OUT === 1'b1 && n < 40) begin
         n++;
         step();
      end
   endtask

   task automatic to_verify();
      idle();
      RESETDONE_IN = 1'b1;
      wait_out("wait_rxreset_low", 0, 1'b0, 50);
      wait_out("wait_align", 1, 1'b1, 10);
      drive(16'hBC95, 2'b10, 2'b10);
      step();
      chk("verify_entry_enc", ENCOMMAALIGN_OUT, 1'b0);
   endtask

   task automatic send_sp(input int n);
      for (int i = 0; i < n; i++) begin
         drive(16'hBC95, 2'b10, 2'b10);
         step();
      end
      idle();
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      int  n;
      bit  seen;

      idle();
      RESETDONE_IN = 1'b0;
      RESET = 1'b1;
      step();
      step();
      chk("reset_rxreset", RXRESET_OUT, 1'b1);
      chk("reset_enc", ENCOMMAALIGN_OUT, 1'b0);
      chk("reset_pol", RXPOLARITY_OUT, 1'b0);
      chk("reset_lane_up", LANE_UP, 1'b0);
      chk("reset_soft", SOFT_ERR, 1'b0);
      chk("reset_hard", HARD_ERR, 1'b0);
      RESET = 1'b0;

      // Nominal bring-up
      count_rxreset(n);
      chk_int("nominal_rst_len", n, 8);
      step();
      chk("wait_no_align", ENCOMMAALIGN_OUT, 1'b0);
      RESETDONE_IN = 1'b1;
      step();
      chk("align_enc_on", ENCOMMAALIGN_OUT, 1'b1);
      step();
      step();
      chk("align_enc_held", ENCOMMAALIGN_OUT, 1'b1);
      drive(16'hBC95, 2'b10, 2'b10);
      step();
      chk("verify_enc_off", ENCOMMAALIGN_OUT, 1'b0);
      send_sp(3);
      chk("three_sp_not_up", LANE_UP, 1'b0);
      send_sp(1);
      chk("four_sp_up", LANE_UP, 1'b1);
      chk("nominal_pol", RXPOLARITY_OUT, 1'b0);

      // Error threshold: 15 consecutive disparity errors
      n = 0;
      for (int i = 0; i < 15; i++) begin
         RXDISPERR_IN = 2'b01;
         step();
         if (SOFT_ERR === 1'b1) n++;
         chk("thr_no_early_hard", HARD_ERR, 1'b0);
      end
      chk_int("thr_soft_count", n, 15);
      idle();
      chk("thr_still_up", LANE_UP, 1'b1);
      step();
      chk("thr_hard", HARD_ERR, 1'b1);
      chk("thr_lane_down", LANE_UP, 1'b0);
      chk("thr_rst", RXRESET_OUT, 1'b1);
      step();
      chk("thr_hard_single", HARD_ERR, 1'b0);

      // Sparse errors: one per 300 cycles leaks away before threshold
      to_verify();
      send_sp(4);
      chk("sparse_up", LANE_UP, 1'b1);
      seen = 0;
      for (int e = 0; e < 5; e++) begin
         RXDISPERR_IN = 2'b01;
         step();
         if (HARD_ERR === 1'b1) seen = 1;
         RXDISPERR_IN = 2'b00;
         for (int j = 0; j < 299; j++) begin
            step();
            if (HARD_ERR === 1'b1) seen = 1;
         end
      end
      chk("sparse_no_hard", seen, 1'b0);
      chk("sparse_still_up", LANE_UP, 1'b1);

      // Buffer error in READY
      RXBUFERR_IN = 1'b1;
      step();
      idle();
      chk("buf_hard", HARD_ERR, 1'b1);
      chk("buf_rst", RXRESET_OUT, 1'b1);
      chk("buf_lane_down", LANE_UP, 1'b0);
      step();
      chk("buf_hard_single", HARD_ERR, 1'b0);

      // Inverted polarity during VERIFY
      to_verify();
      drive(16'hBC4A, 2'b10, 2'b10);
      step();
      idle();
      chk("inv_pol_set", RXPOLARITY_OUT, 1'b1);
      count_rxreset(n);
      chk_int("inv_rst_len", n, 8);
      to_verify();
      send_sp(2);
      drive(16'hBC95, 2'b10, 2'b10);
      RXNOTINTABLE_IN = 2'b10;
      step();
      idle();
      send_sp(3);
      chk("inv_err_cleared_run", LANE_UP, 1'b0);
      send_sp(1);
      chk("inv_up", LANE_UP, 1'b1);
      chk("inv_pol_kept", RXPOLARITY_OUT, 1'b1);

      // Mid-operation reset clears everything including polarity
      RESET = 1'b1;
      RXDISPERR_IN = 2'b01;
      step();
      chk("mid_rst_rxreset", RXRESET_OUT, 1'b1);
      chk("mid_rst_enc", ENCOMMAALIGN_OUT, 1'b0);
      chk("mid_rst_pol", RXPOLARITY_OUT, 1'b0);
      chk("mid_rst_lane_up", LANE_UP, 1'b0);
      chk("mid_rst_soft", SOFT_ERR, 1'b0);
      chk("mid_rst_hard", HARD_ERR, 1'b0);
      RESET = 1'b0;

      // Alignment timeout with only byte-0 commas
      drive(16'h00BC, 2'b01, 2'b01);
      wait_out("to_wait_align", 1, 1'b1, 50);
      n = 0;
      seen = 0;
      while (ENCOMMAALIGN_OUT === 1'b1 && n < 200) begin
         n++;
         if (LANE_UP === 1'b1) seen = 1;
         step();
      end
      chk_int("to_align_len", n, 64);
      chk("to_back_rst", RXRESET_OUT, 1'b1);
      chk("to_never_up", seen, 1'b0);

      // Inverted /SP/ in its data-only form
      to_verify();
      drive(16'h4A4A, 2'b00, 2'b00);
      step();
      idle();
      chk("inv_data_pol", RXPOLARITY_OUT, 1'b1);
      chk("inv_data_rst", RXRESET_OUT, 1'b1);
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
